// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StDrain
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;

    function automatic logic [31:0] word_addr(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry skid buffer holding a fetched {pc, instr, exc} while decode is stalled.
module fetch_skid (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        exc_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        exc_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        exc_q, exc_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        exc_d   = exc_q;
        if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            exc_d   = exc_i;
        end else if (clear_i) begin
            pc_d    = '0;
            instr_d = '0;
            exc_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exc_q   <= exc_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign exc_o   = exc_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: fetch PC, variable-latency imem handshake, IF/ID register.
// Optional IF_ALIGN_CHECK_EN raises AdEL on misaligned fetch instead of issuing a request.
module if_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        stall,
    input  logic        flush_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pcD,
    output logic [31:0] instrD,
    output logic        validD,
    output logic        excD
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  pc_d_q, pc_d_d;
    logic [31:0]  instr_d_q, instr_d_d;
    logic         valid_d_q, valid_d_d;
    logic         exc_d_q, exc_d_d;

    logic         misaligned;
    logic         ack_eff;
    logic         fetch_done;
    logic [31:0]  fetch_word;
    logic         skid_load, skid_clear;
    logic [31:0]  skid_pc, skid_instr;
    logic         skid_exc;

`ifdef IF_ALIGN_CHECK_EN
    assign misaligned = (state_q == StFetch) && (pc_f_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign imem_req   = ((state_q == StFetch) && !misaligned) || (state_q == StDrain);
    assign imem_addr  = (state_q == StDrain) ? drain_addr_q : word_addr(pc_f_q);
    // Acks without an outstanding request are protocol errors and are ignored.
    assign ack_eff    = imem_ack && imem_req;
    assign fetch_done = (state_q == StFetch) && (ack_eff || misaligned);
    assign fetch_word = misaligned ? NOP_INSTR : imem_rdata;

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        drain_addr_d = drain_addr_q;
        pc_d_d       = pc_d_q;
        instr_d_d    = instr_d_q;
        valid_d_d    = valid_d_q;
        exc_d_d      = exc_d_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        if (redirect) begin
            pc_f_d    = npc;
            instr_d_d = NOP_INSTR;
            valid_d_d = 1'b0;
            exc_d_d   = 1'b0;
            case (state_q)
                StFetch: begin
                    if (!fetch_done) begin
                        state_d      = StDrain;
                        drain_addr_d = imem_addr;
                    end
                end
                StHold: begin
                    state_d    = StFetch;
                    skid_clear = 1'b1;
                end
                // The abandoned request still owes an ack; only that ack ends the drain.
                StDrain: state_d = ack_eff ? StFetch : StDrain;
                default: state_d = StFetch;
            endcase
        end else begin
            case (state_q)
                StFetch: begin
                    if (fetch_done && stall) begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end else if (fetch_done) begin
                        pc_d_d    = pc_f_q;
                        instr_d_d = fetch_word;
                        valid_d_d = 1'b1;
                        exc_d_d   = misaligned;
                        pc_f_d    = npc;
                    end else if (!stall) begin
                        instr_d_d = NOP_INSTR;
                        valid_d_d = 1'b0;
                        exc_d_d   = 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        pc_d_d     = skid_pc;
                        instr_d_d  = skid_instr;
                        valid_d_d  = 1'b1;
                        exc_d_d    = skid_exc;
                        pc_f_d     = npc;
                        state_d    = StFetch;
                        skid_clear = 1'b1;
                    end
                end
                StDrain: begin
                    if (ack_eff) begin
                        state_d = StFetch;
                    end
                    if (!stall) begin
                        instr_d_d = NOP_INSTR;
                        valid_d_d = 1'b0;
                        exc_d_d   = 1'b0;
                    end
                end
                default: state_d = StFetch;
            endcase
            if (flush_d) begin
                instr_d_d = NOP_INSTR;
                valid_d_d = 1'b0;
                exc_d_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            pc_f_q       <= RESET_PC;
            drain_addr_q <= '0;
            pc_d_q       <= '0;
            instr_d_q    <= NOP_INSTR;
            valid_d_q    <= 1'b0;
            exc_d_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            drain_addr_q <= drain_addr_d;
            pc_d_q       <= pc_d_d;
            instr_d_q    <= instr_d_d;
            valid_d_q    <= valid_d_d;
            exc_d_q      <= exc_d_d;
        end
    end

    fetch_skid u_skid (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_f_q),
        .instr_i (fetch_word),
        .exc_i   (misaligned),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .exc_o   (skid_exc)
    );

    assign pcF    = pc_f_q;
    assign pcD    = pc_d_q;
    assign instrD = instr_d_q;
    assign validD = valid_d_q;
    assign excD   = exc_d_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle comparison against a transaction-level fetch model
// plus hand-computed literal checkpoints.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        redirect, stall, flush_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pcF, pcD, instrD;
    logic        validD, excD;

    int n_checks = 0;
    int n_pass   = 0;
    bit run      = 1'b0;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .redirect   (redirect),
        .stall      (stall),
        .flush_d    (flush_d),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pcF        (pcF),
        .pcD        (pcD),
        .instrD     (instrD),
        .validD     (validD),
        .excD       (excD)
    );

    always #5 clk = ~clk;

`ifdef IF_ALIGN_CHECK_EN
    localparam bit AlignChk = 1'b1;
`else
    localparam bit AlignChk = 1'b0;
`endif

    // Model: fetch PC, an optional captured word, an optional abandoned request, IF/ID.
    logic [31:0] m_pc_f = 32'h3000;
    bit          m_have_buf = 0;
    logic [31:0] m_buf_pc, m_buf_instr;
    bit          m_buf_exc;
    bit          m_draining = 0;
    logic [31:0] m_drain_addr;
    logic [31:0] m_pc_d = 0, m_instr_d = 0;
    bit          m_valid_d = 0, m_exc_d = 0;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic bit m_bad_pc();
        return AlignChk && (m_pc_f[1:0] != 2'b00) && !m_have_buf && !m_draining;
    endfunction

    function automatic bit m_req();
        return m_draining || (!m_have_buf && !m_bad_pc());
    endfunction

    function automatic logic [31:0] m_addr();
        return m_draining ? m_drain_addr : (m_pc_f & 32'hFFFF_FFFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic bubble();
        m_instr_d = 0;
        m_valid_d = 0;
        m_exc_d   = 0;
    endtask

    task automatic model_step();
        bit          got, bad, done;
        logic [31:0] addr;
        got  = imem_ack && m_req();
        bad  = m_bad_pc();
        addr = m_addr();
        if (m_draining) begin
            if (got) m_draining = 0;
            if (redirect) m_pc_f = npc;
            if (redirect || flush_d || !stall) bubble();
        end else if (m_have_buf) begin
            if (redirect) begin
                m_have_buf = 0;
                m_pc_f = npc;
                bubble();
            end else if (!stall) begin
                m_pc_d = m_buf_pc; m_instr_d = m_buf_instr;
                m_valid_d = 1; m_exc_d = m_buf_exc;
                if (flush_d) bubble();
                m_have_buf = 0;
                m_pc_f = npc;
            end else if (flush_d) begin
                bubble();
            end
        end else begin
            done = got || bad;
            if (redirect) begin
                if (!done) begin
                    m_draining = 1;
                    m_drain_addr = addr;
                end
                m_pc_f = npc;
                bubble();
            end else if (done && stall) begin
                m_have_buf = 1;
                m_buf_pc = m_pc_f; m_buf_instr = bad ? 32'h0 : imem_rdata; m_buf_exc = bad;
                if (flush_d) bubble();
            end else if (done) begin
                m_pc_d = m_pc_f; m_instr_d = bad ? 32'h0 : imem_rdata;
                m_valid_d = 1; m_exc_d = bad;
                if (flush_d) bubble();
                m_pc_f = npc;
            end else if (!stall || flush_d) begin
                bubble();
            end
        end
    endtask

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
            if (m_req()) chk("imem_addr", imem_addr, m_addr());
            chk("pcF", pcF, m_pc_f);
            chk("pcD", pcD, m_pc_d);
            chk("instrD", instrD, m_instr_d);
            chk("validD", {31'b0, validD}, {31'b0, m_valid_d});
            chk("excD", {31'b0, excD}, {31'b0, m_exc_d});
            model_step();
        end
    end

    // tgt == 0 means sequential npc (pcF + 4).
    task automatic step(input bit a, input bit s, input bit f, input bit r,
                        input logic [31:0] tgt);
        imem_ack   = a;
        stall      = s;
        flush_d    = f;
        redirect   = r;
        npc        = (r || tgt != 0) ? tgt : m_pc_f + 32'd4;
        imem_rdata = m_req() ? rdata_of(m_addr()) : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        npc = 0; redirect = 0; stall = 0; flush_d = 0; imem_ack = 0; imem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pcF", pcF, 32'h3000);
        chk("rst_pcD", pcD, 32'h0);
        chk("rst_instrD", instrD, 32'h0);
        chk("rst_validD", {31'b0, validD}, 32'h0);
        chk("rst_excD", {31'b0, excD}, 32'h0);
        reset = 1'b0;
        run = 1'b1;

        // Zero-wait stream
        step(1, 0, 0, 0, 0); chk("zw_pcD0", pcD, 32'h3000); chk("zw_v0", {31'b0, validD}, 1);
        step(1, 0, 0, 0, 0); chk("zw_pcD1", pcD, 32'h3004);
        step(1, 0, 0, 0, 0); chk("zw_pcD2", pcD, 32'h3008); chk("zw_ins2", instrD, 32'hCFF7_3008);

        // Two wait cycles at 0x300C
        step(0, 0, 0, 0, 0); chk("wait_v0", {31'b0, validD}, 0); chk("wait_pcD", pcD, 32'h3008);
        step(0, 0, 0, 0, 0); chk("wait_v1", {31'b0, validD}, 0);
        step(1, 0, 0, 0, 0); chk("wait_pcD2", pcD, 32'h300C); chk("wait_v2", {31'b0, validD}, 1);

        // Stall while the 0x3010 ack arrives; a stray ack in HOLD is ignored
        step(1, 1, 0, 0, 0); chk("hold_req", {31'b0, imem_req}, 0); chk("hold_pcD", pcD, 32'h300C);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0); chk("hold_pcD2", pcD, 32'h300C); chk("hold_v", {31'b0, validD}, 1);
        step(0, 0, 0, 0, 0); chk("rel_pcD", pcD, 32'h3010); chk("rel_ins", instrD, 32'hCFEF_3010);
        chk("rel_pcF", pcF, 32'h3014);

        // Redirect during an unacked fetch of 0x3014
        step(0, 0, 0, 1, 32'h4180);
        chk("drn_addr", imem_addr, 32'h3014); chk("drn_req", {31'b0, imem_req}, 1);
        chk("drn_pcF", pcF, 32'h4180); chk("drn_v", {31'b0, validD}, 0);
        step(0, 0, 0, 0, 0); chk("drn_addr2", imem_addr, 32'h3014);
        step(1, 0, 0, 0, 0); chk("drn_new_addr", imem_addr, 32'h4180);
        chk("drn_v2", {31'b0, validD}, 0);
        step(1, 0, 0, 0, 0); chk("tgt_pcD", pcD, 32'h4180); chk("tgt_v", {31'b0, validD}, 1);

        // flush_d together with stall
        step(0, 1, 1, 0, 0); chk("fl_v", {31'b0, validD}, 0);
        step(1, 0, 0, 0, 0); chk("fl_pcD", pcD, 32'h4184);

        // Redirect out of HOLD drops the captured word
        step(1, 1, 0, 0, 0); chk("hr_req", {31'b0, imem_req}, 0);
        step(0, 0, 0, 1, 32'h5000); chk("hr_pcF", pcF, 32'h5000); chk("hr_v", {31'b0, validD}, 0);
        step(1, 0, 0, 0, 0); chk("hr_pcD", pcD, 32'h5000);

        // Misaligned next PC
        step(1, 0, 0, 0, 32'h3002); chk("mis_pcF", pcF, 32'h3002);
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_req", {31'b0, imem_req}, 0);
        step(0, 0, 0, 0, 0);
        chk("mis_pcD", pcD, 32'h3002); chk("mis_exc", {31'b0, excD}, 1);
        chk("mis_ins", instrD, 32'h0);
`else
        chk("mis_addr", imem_addr, 32'h3000);
        step(1, 0, 0, 0, 0);
        chk("mis_pcD", pcD, 32'h3002); chk("mis_exc", {31'b0, excD}, 0);
        chk("mis_ins", instrD, 32'hCFFF_3000);
`endif
        step(0, 0, 0, 1, 32'h3000);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("end_v", {31'b0, validD}, 1);

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
